// File: rtl/mux8way_arbiter_if.sv
// Bus bundle for the 8-way arbitrated mux: eight valid/ready sources merged onto one tagged sink.
// The arbiter uses modport master; the surrounding sources/sink environment uses modport slave.
interface mux8way_arbiter_if #(
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned N_SRC = 8;
  localparam int unsigned SEL_W = 3;

  logic [N_SRC-1:0]       in_valid;
  logic [N_SRC-1:0]       in_ready;
  logic [N_SRC*WIDTH-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [SEL_W-1:0]       out_sel;

  modport master (
    input  in_valid,
    output in_ready,
    input  in_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_sel
  );

  modport slave (
    output in_valid,
    input  in_ready,
    output in_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_sel
  );
endinterface

// File: rtl/mux8way_arbiter.sv
// 8-way arbitrated mux into a one-entry output register tagged with the source index.
// Define MUX8WAY_ARB_ROUND_ROBIN_EN for round-robin grant; default is fixed priority (index 0 highest).
module mux8way_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mux8way_arbiter_if.master bus
);
  localparam int unsigned N_SRC = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_sel_q;
  logic             can_load;
  logic             any_valid;
  logic             load;
  logic [SEL_W-1:0] grant_idx;
  logic [N_SRC-1:0] grant;

  // rst_n gating keeps every in_ready low while reset is held
  assign can_load  = rst_n & ((state == EMPTY) | bus.out_ready);
  assign any_valid = |bus.in_valid;
  assign load      = can_load & any_valid;

`ifdef MUX8WAY_ARB_ROUND_ROBIN_EN
  logic [SEL_W-1:0] rr_ptr;

  // Descending scan so the smallest offset from rr_ptr is the last (winning) assignment
  always_comb begin
    logic [SEL_W-1:0] idx;
    grant_idx = '0;
    idx       = '0;
    for (int k = int'(N_SRC) - 1; k >= 0; k--) begin
      idx = rr_ptr + SEL_W'(k);
      if (bus.in_valid[idx]) grant_idx = idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (load) begin
      rr_ptr <= grant_idx + SEL_W'(1);
    end
  end
`else
  always_comb begin
    grant_idx = '0;
    for (int k = int'(N_SRC) - 1; k >= 0; k--) begin
      if (bus.in_valid[k]) grant_idx = SEL_W'(k);
    end
  end
`endif

  always_comb begin
    grant = '0;
    if (any_valid) grant[grant_idx] = 1'b1;
  end

  assign bus.in_ready = grant & {N_SRC{can_load}};

  // Output register: a load takes priority, so drain+load in one edge keeps FULL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      out_data_q <= '0;
      out_sel_q  <= '0;
    end else if (load) begin
      state      <= FULL;
      out_data_q <= bus.in_data[32'(grant_idx) * WIDTH +: WIDTH];
      out_sel_q  <= grant_idx;
    end else if ((state == FULL) && bus.out_ready) begin
      state      <= EMPTY;
    end
  end

  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_mux8way_arbiter.sv
// Scoreboard bench for mux8way_arbiter: stimulus pushes expected {data, sel}, a negedge monitor pops on each output transfer.
module tb_mux8way_arbiter;
  localparam int unsigned WIDTH = 16;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [2:0]       sel;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  exp_t sb[$];

  mux8way_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mux8way_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int idx, input logic [WIDTH-1:0] v);
    bus.in_data[idx*WIDTH +: WIDTH] = v;
  endtask

  task automatic expect_word(input logic [WIDTH-1:0] d, input logic [2:0] s);
    exp_t e;
    e.data = d;
    e.sel  = s;
    sb.push_back(e);
  endtask

  // Monitor: a transfer happens on the next posedge whenever out_valid & out_ready are seen here
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("mon_unexpected_word", 32'(bus.out_sel), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("mon_data", 32'(bus.out_data), 32'(e.data));
        check("mon_sel",  32'(bus.out_sel),  32'(e.sel));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.in_valid  = 8'hFF;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) set_word(i, 16'h1000 + 16'(i));

    // 1: reset with all sources valid
    step();
    step();
    check("rst_in_ready",  32'(bus.in_ready),  32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_sel",   32'(bus.out_sel),   32'h0);
    check("rst_out_data",  32'(bus.out_data),  32'h0);
    bus.in_valid = 8'h00;
    rst_n = 1'b1;
    step();
    check("idle_in_ready", 32'(bus.in_ready), 32'h0);

    // 2: single source 5
    set_word(5, 16'hBEEF);
    bus.in_valid = 8'h20;
    #1;
    check("single_in_ready", 32'(bus.in_ready), 32'h20);
    expect_word(16'hBEEF, 3'd5);
    step();
    bus.in_valid  = 8'h00;
    bus.out_ready = 1'b0;
    #1;
    check("single_out_valid", 32'(bus.out_valid), 32'h1);
    check("single_out_data",  32'(bus.out_data),  32'hBEEF);
    check("single_out_sel",   32'(bus.out_sel),   32'h5);

    // 3: backpressure holds BEEF, then drain + load of src0 on one edge
    set_word(0, 16'h1111);
    bus.in_valid = 8'h01;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_in_ready",  32'(bus.in_ready),  32'h0);
      check("bp_out_data",  32'(bus.out_data),  32'hBEEF);
      check("bp_out_valid", 32'(bus.out_valid), 32'h1);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(bus.in_ready), 32'h01);
    expect_word(16'h1111, 3'd0);
    step();
    bus.in_valid = 8'h00;
    #1;
    check("bp_load_valid", 32'(bus.out_valid), 32'h1);
    check("bp_load_sel",   32'(bus.out_sel),   32'h0);
    check("bp_load_data",  32'(bus.out_data),  32'h1111);
    step();
    check("bp_drained", 32'(bus.out_valid), 32'h0);

    // Reset pulse so contention starts from a known pointer
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) set_word(i, 16'hA000 + 16'(i));
`ifdef MUX8WAY_ARB_ROUND_ROBIN_EN
    // 4: all valid, round robin walks 0..7 then wraps to 0
    begin
      logic [2:0] rr_seq [0:8];
      rr_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
      bus.in_valid = 8'hFF;
      for (int c = 0; c < 9; c++) begin
        #1;
        check("rr_in_ready", 32'(bus.in_ready), 32'h1 << rr_seq[c]);
        expect_word(16'hA000 + 16'(rr_seq[c]), rr_seq[c]);
        step();
      end
    end
`else
    // 5: fixed priority, src2 always beats src7
    bus.in_valid = 8'h84;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("fp_in_ready", 32'(bus.in_ready), 32'h04);
      expect_word(16'hA002, 3'd2);
      step();
    end
`endif
    bus.in_valid = 8'h00;
    step();
    step();
    check("cont_drained", 32'(bus.out_valid), 32'h0);

    // 6: reset while FULL discards the held word immediately
    set_word(3, 16'hD003);
    bus.out_ready = 1'b0;
    bus.in_valid  = 8'h08;
    step();
    bus.in_valid = 8'h00;
    #1;
    check("mid_full", 32'(bus.out_valid), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    check("mid_rst_sel",   32'(bus.out_sel),   32'h0);
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    set_word(7, 16'hE007);
    set_word(0, 16'hE000);
    bus.in_valid = 8'h80;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'h80);
    expect_word(16'hE007, 3'd7);
    step();
    // Pointer must have wrapped 7 -> 0, so src0 wins over src7 either way
    bus.in_valid = 8'h81;
    #1;
    check("post_rst_out_sel", 32'(bus.out_sel), 32'h7);
    check("wrap_in_ready", 32'(bus.in_ready), 32'h01);
    expect_word(16'hE000, 3'd0);
    step();
    bus.in_valid = 8'h00;
    step();
    step();
    check("end_idle", 32'(bus.out_valid), 32'h0);
    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
